// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt responder: maskable FSM encoding and default sizing.
package intc_pkg;

  localparam int unsigned INTC_NUM_IRQ = 8;
  localparam int unsigned INTC_VEC_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/intc_responder_if.sv
// CPU-facing handshake of the interrupt responder: request/disable outputs and acknowledge/EOI inputs.
interface intc_responder_if
  import intc_pkg::*;
#(
  parameter int unsigned VEC_W = INTC_VEC_W
);
  logic             isInterrupted;
  logic             INA;
  logic             eoi_int;
  logic             eoi_nmi;
  logic             INT;
  logic             NMI;
  logic             INTD;
  logic [VEC_W-1:0] vector;
  logic             vector_valid;
  logic             nmi_active;

  modport slave (
    input  isInterrupted, INA, eoi_int, eoi_nmi,
    output INT, NMI, INTD, vector, vector_valid, nmi_active
  );

  modport master (
    output isInterrupted, INA, eoi_int, eoi_nmi,
    input  INT, NMI, INTD, vector, vector_valid, nmi_active
  );
endinterface

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: reports the lowest set request index and whether any is set.
module intc_prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intc_responder.sv
// Interrupt responder: prioritises maskable IRQs plus an edge-triggered NMI toward the CPU.
// Build option INTC_EDGE_EN: edge-triggered IRQ lines; level-sensitive when undefined.
module intc_responder
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = INTC_NUM_IRQ,
  parameter int unsigned VEC_W   = INTC_VEC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_req,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_din,
  input  logic               ie_set,
  input  logic               ie_clr,
  intc_responder_if.slave    cpu
);

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   vec_r, vec_nxt, cand_idx;
  logic [NUM_IRQ-1:0] pend, pend_nxt, mask, irq_q, rise, clr, cand;
  logic               ie, nmi_pend, nmi_act, nmi_q, isint_q;
  logic               ack, ack_int, ack_nmi, cand_any;

  assign ack     = cpu.isInterrupted & ~isint_q;
  assign ack_int = ack & cpu.INA & (state == REQ);
  assign ack_nmi = ack & ~cpu.INA & nmi_pend;
  assign rise    = irq & ~irq_q;
  assign cand    = pend & ~mask;

  intc_prio_enc #(
    .N(NUM_IRQ),
    .W(VEC_W)
  ) u_prio (
    .req(cand),
    .idx(cand_idx),
    .any(cand_any)
  );

  // A fresh request on the line being acked in the same cycle must survive the clear.
  always_comb begin
    clr = '0;
    if (ack_int) clr[vec_r] = 1'b1;
`ifdef INTC_EDGE_EN
    pend_nxt = (pend & ~clr) | rise;
`else
    pend_nxt = irq & ~(clr & ~rise);
`endif
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_r;
    case (state)
      IDLE: if (ie && cand_any) begin
        state_nxt = REQ;
        vec_nxt   = cand_idx;
      end
      REQ:     if (ack_int) state_nxt = SVC;
      SVC:     if (cpu.eoi_int) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec_r   <= '0;
      pend    <= '0;
      mask    <= '0;
      irq_q   <= '0;
      ie      <= 1'b0;
      nmi_q   <= 1'b0;
      isint_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      vec_r   <= vec_nxt;
      pend    <= pend_nxt;
      irq_q   <= irq;
      nmi_q   <= nmi_req;
      isint_q <= cpu.isInterrupted;
      if (mask_wr) mask <= mask_din;
      if (ie_clr)      ie <= 1'b0;
      else if (ie_set) ie <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_pend <= 1'b0;
      nmi_act  <= 1'b0;
    end else begin
      if (nmi_req && !nmi_q) nmi_pend <= 1'b1;
      else if (ack_nmi)      nmi_pend <= 1'b0;
      if (ack_nmi)          nmi_act <= 1'b1;
      else if (cpu.eoi_nmi) nmi_act <= 1'b0;
    end
  end

  assign cpu.INT          = (state == REQ);
  assign cpu.NMI          = nmi_pend;
  assign cpu.INTD         = (state == SVC) | ~ie;
  assign cpu.vector       = vec_r;
  assign cpu.vector_valid = (state != IDLE);
  assign cpu.nmi_active   = nmi_act;

endmodule

// File: tb/tb_intc_responder.sv
// Scoreboard bench for intc_responder: stimulus queues expected output snapshots with their edge number.
module tb_intc_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic       nmi_req, mask_wr, ie_set, ie_clr;
  logic [7:0] mask_din;

  intc_responder_if #(.VEC_W(3)) cpu ();

  intc_responder #(
    .NUM_IRQ(8),
    .VEC_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq(irq),
    .nmi_req(nmi_req),
    .mask_wr(mask_wr),
    .mask_din(mask_din),
    .ie_set(ie_set),
    .ie_clr(ie_clr),
    .cpu(cpu)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // snapshot bits: INT NMI INTD vector_valid vector[2:0] nmi_active
  typedef struct {
    logic [7:0] snap;
    bit         full;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] prev = 8'hxx;
  logic [7:0] raw, cur, got;
  exp_t       e;

  function automatic logic [7:0] S(input bit i, input bit n, input bit d, input bit v,
                                   input int vec, input bit a);
    logic [2:0] vb;
    vb = vec[2:0];
    return {i, n, d, v, vb, a};
  endfunction

  task automatic push_exp(input logic [7:0] s, input int n);
    exp_t x;
    x.snap = s; x.full = 1'b0; x.at = cyc + n;
    sb.push_back(x);
  endtask

  task automatic push_rst(input int at);
    exp_t x;
    x.snap = S(0, 0, 1, 0, 0, 0); x.full = 1'b1; x.at = at;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // vector is only meaningful while vector_valid, except in reset entries
  always @(negedge clk) begin
    raw = {cpu.INT, cpu.NMI, cpu.INTD, cpu.vector_valid, cpu.vector, cpu.nmi_active};
    cur = raw[4] ? raw : (raw & 8'hF1);
    if (cur !== prev) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = sb.pop_front();
        got = e.full ? raw : cur;
        if (got !== e.snap || cyc != e.at) begin
          n_err++;
          $display("FAIL out_change got=%b@%0d required=%b@%0d", got, cyc, e.snap, e.at);
        end
      end
      prev = cur;
    end else if (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_change got=%b@%0d required=%b@%0d", cur, cyc, e.snap, e.at);
    end
  end

  initial begin
    rst_n = 1'b1; irq = '0; nmi_req = 0; mask_wr = 0; mask_din = '0; ie_set = 0; ie_clr = 0;
    cpu.isInterrupted = 0; cpu.INA = 0; cpu.eoi_int = 0; cpu.eoi_nmi = 0;
    push_rst(1);
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    ie_set = 1; push_exp(S(0, 0, 0, 0, 0, 0), 1);
    tick(1); ie_set = 0;
    tick(1);

    // single pulse on irq[5]
    irq[5] = 1; push_exp(S(1, 0, 0, 1, 5, 0), 2);
    tick(1); irq[5] = 0;
    tick(3);
    cpu.isInterrupted = 1; cpu.INA = 1; push_exp(S(0, 0, 1, 1, 5, 0), 1);
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    cpu.eoi_int = 1; push_exp(S(0, 0, 0, 0, 0, 0), 1);
    tick(1); cpu.eoi_int = 0;
    tick(1);
    cpu.eoi_int = 1;                       // ignored outside SVC
    tick(1); cpu.eoi_int = 0;
    tick(1);

    // simultaneous irq[2] and irq[6]
    irq[2] = 1; irq[6] = 1; push_exp(S(1, 0, 0, 1, 2, 0), 2);
    tick(3);
    cpu.isInterrupted = 1; irq[2] = 0; push_exp(S(0, 0, 1, 1, 2, 0), 1);
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    cpu.eoi_int = 1; push_exp(S(0, 0, 0, 0, 0, 0), 1); push_exp(S(1, 0, 0, 1, 6, 0), 2);
    tick(1); cpu.eoi_int = 0;
    tick(2);
    cpu.isInterrupted = 1; irq[6] = 0; push_exp(S(0, 0, 1, 1, 6, 0), 1);
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    cpu.eoi_int = 1; push_exp(S(0, 0, 0, 0, 0, 0), 1);
    tick(1); cpu.eoi_int = 0;
    tick(1);

    // masked line, then unmask (decision on the write edge still uses the old mask)
    mask_wr = 1; mask_din = 8'h04;
    tick(1); mask_wr = 0; irq[2] = 1;
    tick(4);
    mask_wr = 1; mask_din = 8'h00; push_exp(S(1, 0, 0, 1, 2, 0), 2);
    tick(1); mask_wr = 0;
    tick(2);
    // ie cleared while REQ: INT and vector held
    ie_clr = 1; push_exp(S(1, 0, 1, 1, 2, 0), 1);
    tick(1); ie_clr = 0;
    tick(2);
    cpu.isInterrupted = 1; irq[2] = 0; push_exp(S(0, 0, 1, 1, 2, 0), 1);
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    cpu.eoi_int = 1; push_exp(S(0, 0, 1, 0, 0, 0), 1);
    tick(1); cpu.eoi_int = 0;
    ie_set = 1; push_exp(S(0, 0, 0, 0, 0, 0), 1);
    tick(1); ie_set = 0;
    tick(1);

    // NMI during SVC of vector 3
    irq[3] = 1; push_exp(S(1, 0, 0, 1, 3, 0), 2);
    tick(3);
    cpu.isInterrupted = 1; irq[3] = 0; push_exp(S(0, 0, 1, 1, 3, 0), 1);
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    cpu.isInterrupted = 1; cpu.INA = 0;    // NMI ack with nothing pending: ignored
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    nmi_req = 1; push_exp(S(0, 1, 1, 1, 3, 0), 1);
    tick(2);
    cpu.eoi_nmi = 1;                       // ignored while not active
    tick(1); cpu.eoi_nmi = 0;
    cpu.isInterrupted = 1; push_exp(S(0, 0, 1, 1, 3, 1), 1);
    tick(1); cpu.isInterrupted = 0; nmi_req = 0;
    tick(1);
    cpu.eoi_nmi = 1; push_exp(S(0, 0, 1, 1, 3, 0), 1);
    tick(1); cpu.eoi_nmi = 0;
    cpu.isInterrupted = 1; cpu.INA = 1;    // INT ack in SVC: ignored
    tick(1); cpu.isInterrupted = 0;
    tick(1);

    // reset while in SVC with an NMI in service
    nmi_req = 1; cpu.INA = 0; push_exp(S(0, 1, 1, 1, 3, 0), 1);
    tick(1); nmi_req = 0;
    tick(1);
    cpu.isInterrupted = 1; push_exp(S(0, 0, 1, 1, 3, 1), 1);
    tick(1); cpu.isInterrupted = 0;
    tick(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0; push_rst(cyc);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL never_seen got=none required=%b@%0d", e.snap, e.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intc_responder.md
# intc_responder

Interrupt controller sitting between peripheral IRQ lines and the multicycle CPU controller. Collects up to NUM_IRQ maskable requests plus one non-maskable request, prioritises them, and drives the CPU's INT, NMI and INTD inputs. Consumes the CPU's acknowledge (isInterrupted, INA) to retire requests and track in-service state until the ISR signals end-of-interrupt.

## Interface
- NUM_IRQ, 8: number of maskable IRQ lines; legal range 2..16.
- VEC_W, 3: vector width; equals clog2(NUM_IRQ).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- irq  in  NUM_IRQ  peripheral requests, synchronous to clk; index 0 is highest priority.
- nmi_req  in  1  non-maskable request, synchronous.
- mask_wr  in  1  load mask register from mask_din this cycle.
- mask_din  in  NUM_IRQ  new mask; 1 = line masked.
- ie_set / ie_clr  in  1 each  set / clear global maskable enable; ie_clr wins if both asserted.
- isInterrupted  in  1  CPU acknowledge level; its rising edge is the ack event.
- INA  in  1  CPU ack type: 1 = INT taken, 0 = NMI taken.
- eoi_int / eoi_nmi  in  1 each  end-of-interrupt pulses from ISR.
- INT  out  1  maskable request to CPU.
- NMI  out  1  non-maskable request to CPU.
- INTD  out  1  maskable-interrupt disable to CPU.
- vector  out  VEC_W  index of the request being offered / serviced.
- vector_valid  out  1  vector is meaningful.
- nmi_active  out  1  NMI in service.

## Operation
- Pending register pend[NUM_IRQ]; candidates = pend & ~mask.
- Maskable FSM states: IDLE, REQ, SVC.
  - IDLE -> REQ when ie=1 and candidates != 0; vector latched to lowest set candidate index on that edge.
  - REQ -> SVC on ack event with INA=1; pend[vector] cleared on same edge.
  - SVC -> IDLE on eoi_int.
  - REQ is held until acked: later mask/ie changes do not withdraw INT or change vector (CPU has already latched INT).
- INT = (state==REQ). INTD = (state==SVC) | ~ie. vector_valid = (state!=IDLE).
- NMI path independent of FSM: nmi_pend set on nmi_req rising edge; NMI = nmi_pend; ack event with INA=0 clears nmi_pend and sets nmi_active; eoi_nmi clears nmi_active. NMI is offered in any maskable state, including SVC.
- Ignored events: INA=1 ack outside REQ; INA=0 ack with nmi_pend=0; eoi_int outside SVC; eoi_nmi with nmi_active=0.
- Simultaneous: ack clearing pend[i] and new request on line i same cycle -> pend[i] ends 1. mask_wr takes effect on the same edge as a concurrent IDLE->REQ decision only from the next cycle (decision uses old mask).

## Timing
- Reset values: INT=0, NMI=0, INTD=1 (ie=0), vector=0, vector_valid=0, nmi_active=0; pend=0, mask=0, nmi_pend=0, state=IDLE, edge history=0.
- irq rise sampled at edge k -> pend set at k -> REQ at k+1 -> INT high after k+1 (2-edge latency, ie=1, unmasked).
- nmi_req rise sampled at edge k -> NMI high after k.
- Ack event detected at edge where isInterrupted=1 and previous sample 0; INT/NMI drop after that edge.
- eoi_int at edge k -> IDLE after k; next REQ no earlier than edge k+1.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous).
- All outputs are registered or decoded purely from registered state; no input-to-output combinational path.

## Configuration
- INTC_EDGE_EN defined: irq lines are edge-triggered; a rising edge sets pend[i]; pend[i] clears only on ack.
- Undefined: level-sensitive; pend[i] follows irq[i] each cycle, except ack suppresses pend[vector] for one cycle; source must drop irq before eoi_int or it re-requests.
- NMI is always edge-triggered regardless of macro.

## Structure
- Package intc_pkg: FSM state encoding (IDLE, REQ, SVC), NUM_IRQ default, VEC_W default.
- Sub-module intc_prio_enc: combinational lowest-index-first encoder, outputs index and any-set flag.

## Test plan
- ie=1, mask=0, pulse irq[5] -> INT=1 two edges later, vector=5; isInterrupted rise with INA=1 -> INT=0, INTD=1, pend[5]=0; eoi_int -> INTD=0, vector_valid=0.
- irq[2] and irq[6] rise same cycle -> vector=2 served first; after eoi_int, second REQ with vector=6.
- mask=0x04, irq[2] rise -> no INT; write mask=0 -> INT after next edge with vector=2.
- During SVC of vector 3, nmi_req rise -> NMI=1 while INTD stays 1; ack INA=0 -> NMI=0, nmi_active=1; eoi_nmi -> nmi_active=0, still SVC.
- In REQ, assert ie_clr -> INT stays 1, vector unchanged until ack.
- rst_n low while in SVC with nmi_active=1 -> all outputs at reset values immediately, INTD=1.
